// File: rtl/design_select_hub.sv
// Selector hub for a multi-project tapeout: shares one chip IO bus among
// NUM_DESIGNS user slots, gating inputs, resets and outputs by des_sel.
module design_select_hub #(
  parameter int unsigned NUM_DESIGNS = 64,
  parameter int unsigned IO_W        = 12
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [IO_W-1:0]             io_in,
  output logic [IO_W-1:0]             io_out,
  input  logic [5:0]                  des_sel,
  input  logic                        hold_if_not_sel,
  input  logic                        sync_inputs,
  output logic [NUM_DESIGNS*IO_W-1:0] slot_io_in,
  input  logic [NUM_DESIGNS*IO_W-1:0] slot_io_out,
  output logic [NUM_DESIGNS-1:0]      slot_reset
);

  localparam int unsigned SEL_W = 6;

  logic                   sel_valid;
  logic [NUM_DESIGNS-1:0] selected;
  logic [IO_W-1:0]        sync_s1;
  logic [IO_W-1:0]        sync_s2;
  logic [IO_W-1:0]        in_eff;

  // Widen by one bit so NUM_DESIGNS=64 compares correctly against a 6-bit select.
  assign sel_valid = ({1'b0, des_sel} < (SEL_W + 1)'(NUM_DESIGNS));

  // One-hot slot decode; all zero when the select is out of range.
  always_comb begin
    selected = '0;
    for (int unsigned i = 0; i < NUM_DESIGNS; i++) begin
      selected[i] = sel_valid && (des_sel == SEL_W'(i));
    end
  end

  // Two-flop input synchronizer, free-running regardless of sync_inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= io_in;
      sync_s2 <= sync_s1;
    end
  end

  assign in_eff = sync_inputs ? sync_s2 : io_in;

  // Per-slot input gating and reset generation.
  for (genvar g = 0; g < NUM_DESIGNS; g++) begin : g_slot
    assign slot_io_in[g*IO_W +: IO_W] = selected[g] ? in_eff : '0;
    assign slot_reset[g]              = reset | (hold_if_not_sel & ~selected[g]);
  end

  // Output mux; unselected slots contribute nothing.
  always_comb begin
    io_out = '0;
    for (int unsigned i = 0; i < NUM_DESIGNS; i++) begin
      if (selected[i]) begin
        io_out = slot_io_out[i*IO_W +: IO_W];
      end
    end
  end

endmodule

// File: tb/tb_design_select_hub.sv
// Scoreboard bench for design_select_hub with four slots: expectations are
// queued as stimulus is applied and compared when outputs are sampled.
module tb_design_select_hub;

  localparam int unsigned ND = 4;
  localparam int unsigned W  = 12;

  logic              clock = 1'b0;
  logic              reset;
  logic [W-1:0]      io_in;
  logic [W-1:0]      io_out;
  logic [5:0]        des_sel;
  logic              hold_if_not_sel;
  logic              sync_inputs;
  logic [ND*W-1:0]   slot_io_in;
  logic [ND*W-1:0]   slot_io_out;
  logic [ND-1:0]     slot_reset;

  int n_tests = 0;
  int n_fail  = 0;

  string       tag_q[$];
  logic [63:0] exp_q[$];

  design_select_hub #(.NUM_DESIGNS(ND), .IO_W(W)) dut (
    .clock           (clock),
    .reset           (reset),
    .io_in           (io_in),
    .io_out          (io_out),
    .des_sel         (des_sel),
    .hold_if_not_sel (hold_if_not_sel),
    .sync_inputs     (sync_inputs),
    .slot_io_in      (slot_io_in),
    .slot_io_out     (slot_io_out),
    .slot_reset      (slot_reset)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [63:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 64'(exp_q.size()), 64'd1);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  initial begin
    reset           = 1'b1;
    io_in           = '0;
    des_sel         = 6'd2;
    hold_if_not_sel = 1'b0;
    sync_inputs     = 1'b0;
    slot_io_out     = {12'h333, 12'hA5C, 12'h111, 12'h0EE};

    // Reset held for five cycles
    @(negedge clock);
    #1;
    push_exp("rst_slot_reset", 64'hF);  pop_chk(64'(slot_reset));
    push_exp("rst_slot_io_in", 64'h0);  pop_chk(64'(slot_io_in));
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    push_exp("rel_slot_reset", 64'h0);  pop_chk(64'(slot_reset));

    // Unsynchronized routing to slot 2
    @(negedge clock);
    io_in = 12'h123;
    push_exp("async_slot_io_in", 64'h000_123_000_000);
    push_exp("async_io_out", 64'hA5C);
    #1;
    pop_chk(64'(slot_io_in));
    pop_chk(64'(io_out));

    // Synchronized path: two rising edges of latency
    @(negedge clock);
    sync_inputs = 1'b1;
    io_in = 12'h000;
    repeat (3) @(negedge clock);
    io_in = 12'hFFF;
    push_exp("sync_edge1", 64'h0);
    push_exp("sync_edge2", 64'h000_FFF_000_000);
    @(posedge clock); #1;
    pop_chk(64'(slot_io_in));
    @(posedge clock); #1;
    pop_chk(64'(slot_io_in));

    // Reset mid-stream clears the synchronizer immediately
    @(negedge clock);
    reset = 1'b1;
    push_exp("midrst_slot_io_in", 64'h0);
    push_exp("midrst_slot_reset", 64'hF);
    push_exp("midrst_io_out", 64'hA5C);
    #1;
    pop_chk(64'(slot_io_in));
    pop_chk(64'(slot_reset));
    pop_chk(64'(io_out));
    @(negedge clock);
    reset = 1'b0;
    sync_inputs = 1'b0;

    // Hold unselected slots in reset, then move the selection
    @(negedge clock);
    hold_if_not_sel = 1'b1;
    des_sel = 6'd1;
    push_exp("hold_sel1", 64'b1101);
    #1; pop_chk(64'(slot_reset));
    des_sel = 6'd3;
    push_exp("hold_sel3", 64'b0111);
    push_exp("hold_sel3_io_out", 64'h333);
    #1;
    pop_chk(64'(slot_reset));
    pop_chk(64'(io_out));

    // Out-of-range select
    @(negedge clock);
    des_sel = 6'd40;
    io_in = 12'h7FF;
    push_exp("inv_io_out", 64'h0);
    push_exp("inv_slot_io_in", 64'h0);
    push_exp("inv_slot_reset_hold", 64'hF);
    #1;
    pop_chk(64'(io_out));
    pop_chk(64'(slot_io_in));
    pop_chk(64'(slot_reset));
    hold_if_not_sel = 1'b0;
    push_exp("inv_slot_reset_nohold", 64'h0);
    #1; pop_chk(64'(slot_reset));

    // Output mux sweep across all slots
    @(negedge clock);
    slot_io_out = {12'h103, 12'h102, 12'h101, 12'h100};
    for (int i = 0; i < int'(ND); i++) begin
      des_sel = 6'(i);
      push_exp($sformatf("mux_sel%0d", i), 64'(12'h100 + 12'(i)));
      push_exp($sformatf("mux_in_sel%0d", i), 64'(48'(io_in) << (i * int'(W))));
      #1;
      pop_chk(64'(io_out));
      pop_chk(64'(slot_io_in));
    end

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
